seq_detect_ctrl: RTL
====================

SEQ_DETECT_CTRL -- requirements
Module: seq_detect_ctrl

Interface
REQ-001 Parameter: WIDTH, 8, bits per input word; serialized MSB first.
REQ-002 Parameter: CNT_W, 16, width of the total-match counter.
REQ-003 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: rst  input  1  reset; asynchronous and active-low.
REQ-005 Port: in_data  input  WIDTH  word to scan.
REQ-006 Port: in_valid  input  1  in_data, pat and ovl are valid.
REQ-007 Port: in_ready  output  1  block can accept a word.
REQ-008 Port: pat  input  3  3-bit target pattern, first-received bit in pat[2].
REQ-009 Port: ovl  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-010 Port: abort  input  1  discards the word in progress.
REQ-011 Port: hit  output  1  registered one-cycle pulse per detected match.
REQ-012 Port: out_valid  output  1  result for one word is available.
REQ-013 Port: out_ready  input  1  consumer accepts the result.
REQ-014 Port: out_count  output  3  number of matches in the word (0..6).
REQ-015 Port: tot_matches  output  CNT_W  saturating total of matches since reset.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE; any unused encoding SHALL go to IDLE.
REQ-017 in_ready SHALL be 1 only in IDLE, combinationally from state.
REQ-018 A word is accepted on a rising edge where in_valid=1 and in_ready=1.
  - At acceptance: in_data goes to the shift register; pat and ovl go to config registers; the history register, bit counter and out_count clear to 0.
  - The state then moves to SHIFT.
REQ-019 In SHIFT, one bit SHALL be consumed per clock, MSB first, for WIDTH cycles.
  - Acceptance at edge N: bit i is consumed at edge N+1+i.
REQ-020 A match SHALL be declared on a consumed bit when the last 3 consumed bits equal the latched pat AND at least 3 bits have been consumed since the last history clear.
REQ-021 The history clear point depends on mode:
  - ovl=1: history SHALL clear only at word acceptance.
  - ovl=0: the history valid-count SHALL also clear to 0 on every match.
REQ-022 On each match, the following SHALL happen at that same edge:
  - hit is 1 for exactly the next cycle;
  - out_count increments;
  - tot_matches increments, saturating at all-ones with no wrap.
REQ-023 After the WIDTH-th bit (edge N+WIDTH), the state SHALL be DONE, with out_valid=1 and out_count stable.
REQ-024 In DONE, out_valid SHALL stay 1 and out_count SHALL stay held until an edge with out_ready=1; the state then goes to IDLE.
REQ-025 Output handshake and input acceptance SHALL never occur on the same edge, because in_ready=0 in DONE.
  - The earliest next acceptance is one cycle after the out handshake.
REQ-026 abort=1 in SHIFT SHALL move the state to IDLE at the next edge with no out_valid.
  - Matches already counted remain in tot_matches.
  - A hit for a match on that same edge SHALL be suppressed and not counted.
REQ-027 abort SHALL be ignored in IDLE and DONE.
REQ-028 in_valid, pat and ovl changes outside acceptance SHALL have no effect on a word in progress.
REQ-029 Latency from acceptance to out_valid SHALL be WIDTH cycles, and the throughput limit SHALL be one word per WIDTH+2 cycles.

Reset
REQ-030 While rst=0, the following SHALL hold asynchronously:
  - state = IDLE;
  - in_ready=1;
  - out_valid=0, hit=0, out_count=0, tot_matches=0;
  - shift, history and config registers = 0.
REQ-031 Reset asserted mid-SHIFT or in DONE SHALL discard the word with no out_valid.
REQ-032 The first acceptance SHALL be possible on the first rising edge after rst returns to 1.

Verification
REQ-033 Overlapping 101: in_data=0xAA, pat=3'b101, ovl=1 -> hit pulses after bits 2, 4 and 6; out_count=3 at edge N+8; tot_matches=3.
REQ-034 Non-overlapping 101: in_data=0xAA, pat=3'b101, ovl=0 -> hits after bits 2 and 6; out_count=2.
REQ-035 Pattern 111, both modes:
  - in_data=0xFF, pat=3'b111, ovl=1 -> out_count=6.
  - Same word with ovl=0 -> out_count=2.
  - Back-to-back, these give tot_matches=8.
REQ-036 Output backpressure: hold out_ready=0 for 5 cycles in DONE with in_valid=1 -> out_valid and out_count held; in_ready=0; no acceptance.
  - Then out_ready=1 -> IDLE next cycle; acceptance one cycle later.
REQ-037 Abort and reset interruptions:
  - abort=1 at bit 4 of 0xAA (ovl=1) -> IDLE with no out_valid; tot_matches=1.
  - Separately, rst=0 at bit 3 -> all outputs at reset values immediately.
REQ-038 Saturation: force CNT_W=4, then apply 3 words of 0xFF with ovl=1 -> tot_matches stops at 15; out_count is still 6 per word.

Source files
------------

// File: rtl/seq_detect_ctrl.sv
// Serial 3-bit pattern detector: accepts one word, shifts it MSB first, counts
// pattern matches (overlapping or not) and hands out a per-word match count.
module seq_detect_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       pat,
    input  logic             ovl,
    input  logic             abort,
    output logic             hit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_count,
    output logic [CNT_W-1:0] tot_matches
);

    // state | meaning
    // IDLE  | waiting for a word, in_ready=1
    // SHIFT | consuming one bit per clock, MSB first
    // DONE  | out_count valid, waiting for out_ready
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam int BCW = $clog2(WIDTH + 1);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] shift_reg;
    logic [2:0]       hist;
    logic [1:0]       hist_cnt;
    logic [BCW-1:0]   bit_cnt;
    logic [2:0]       pat_q;
    logic             ovl_q;

    logic       bit_in;
    logic [2:0] hist_nxt;
    logic [1:0] cnt_inc;
    logic       match;
    logic       last_bit;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_comb begin
        bit_in   = shift_reg[WIDTH-1];
        hist_nxt = {hist[1:0], bit_in};
        cnt_inc  = (hist_cnt == 2'd3) ? 2'd3 : hist_cnt + 2'd1;
        match    = (state == SHIFT) && (cnt_inc == 2'd3) && (hist_nxt == pat_q);
        last_bit = (bit_cnt == LAST_BIT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            shift_reg   <= '0;
            hist        <= '0;
            hist_cnt    <= '0;
            bit_cnt     <= '0;
            pat_q       <= '0;
            ovl_q       <= 1'b0;
            hit         <= 1'b0;
            out_count   <= '0;
            tot_matches <= '0;
        end else begin
            hit <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shift_reg <= in_data;
                        pat_q     <= pat;
                        ovl_q     <= ovl;
                        hist      <= '0;
                        hist_cnt  <= '0;
                        bit_cnt   <= '0;
                        out_count <= '0;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    // an abort drops the word, including any match on this edge
                    if (abort) begin
                        state <= IDLE;
                    end else begin
                        shift_reg <= shift_reg << 1;
                        hist      <= hist_nxt;
                        bit_cnt   <= bit_cnt + BCW'(1);
                        if (match) begin
                            hit       <= 1'b1;
                            out_count <= out_count + 3'd1;
                            if (tot_matches != {CNT_W{1'b1}})
                                tot_matches <= tot_matches + CNT_W'(1);
                            hist_cnt  <= ovl_q ? cnt_inc : 2'd0;
                        end else begin
                            hist_cnt  <= cnt_inc;
                        end
                        if (last_bit)
                            state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
